// File: rtl/mem_responder_if.sv
// Request/response bus between the processor memory port (master) and mem_responder (slave).
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26
);
    logic                  READ;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  READY;
    logic                  BUSY;
    logic                  ERR;

    modport master (output READ, WRITE, ADDR, DATA_IN, input DATA_OUT, READY, BUSY, ERR);
    modport slave  (input READ, WRITE, ADDR, DATA_IN, output DATA_OUT, READY, BUSY, ERR);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: programmable wait states, one-cycle READY pulse.
// Optional MEM_ADDR_CHECK_EN flags out-of-range addresses through ERR instead of aliasing.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 26,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic                  r_rd;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_req;
    logic                  w_acc;
    logic                  w_acc_rd;
    logic [DEPTH_LOG2-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_wdata;
    logic                  w_oor;

    assign w_req = bus.READ | bus.WRITE;

    // With zero wait states the access happens on the sampling edge, so use live inputs.
    assign w_acc_rd    = (r_state == S_IDLE) ? bus.READ : r_rd;
    assign w_acc_addr  = (r_state == S_IDLE) ? bus.ADDR[DEPTH_LOG2-1:0] : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? bus.DATA_IN : r_wdata;

`ifdef MEM_ADDR_CHECK_EN
    logic r_oor;
    logic w_oor_in;
    assign w_oor_in = |bus.ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
    assign w_oor    = (r_state == S_IDLE) ? w_oor_in : r_oor;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                              r_oor <= 1'b0;
        else if (r_state == S_IDLE && w_req)  r_oor <= w_oor_in;
    end
`else
    assign w_oor = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = S_RESP;
                        w_acc       = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_acc       = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_acc & w_oor;
            if (r_state == S_IDLE && w_req) begin
                r_rd    <= bus.READ;
                r_addr  <= bus.ADDR[DEPTH_LOG2-1:0];
                r_wdata <= bus.DATA_IN;
            end
            if (w_acc && w_acc_rd)
                r_dout <= w_oor ? '1 : r_mem[w_acc_addr];
        end
    end

    // Array is not reset; the RST gate keeps an aborted write from landing.
    always_ff @(posedge CLK) begin
        if (!RST && w_acc && !w_acc_rd && !w_oor)
            r_mem[w_acc_addr] <= w_acc_wdata;
    end

    assign bus.DATA_OUT = r_dout;
    assign bus.READY    = (r_state == S_RESP);
    assign bus.BUSY     = (r_state != S_IDLE);
    assign bus.ERR      = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_mem_responder;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] q_exp [$];
    logic [31:0] last_a;

    always #5 CLK = ~CLK;

    mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(26)) ifa ();
    mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(26)) ifb ();

    mem_responder #(.WAIT_CYCLES(2)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));
    mem_responder #(.WAIT_CYCLES(0)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [25:0] a, input logic [31:0] d);
        if (sel) begin ifb.READ = rd; ifb.WRITE = wr; ifb.ADDR = a; ifb.DATA_IN = d; end
        else     begin ifa.READ = rd; ifa.WRITE = wr; ifa.ADDR = a; ifa.DATA_IN = d; end
    endtask

    // One access: expected DATA_OUT at READY is pushed when the request is driven.
    task automatic access(input string tag, input bit sel, input logic rd, input logic wr,
                          input logic [25:0] a, input logic [31:0] d,
                          input logic [31:0] exp_dout, input logic exp_err);
        int rdy_edge;
        int busy_n;
        int rdy_n;
        logic rdy, bsy, err;
        logic [31:0] dout;
        rdy_edge = -1; busy_n = 0; rdy_n = 0;
        @(negedge CLK);
        drive(sel, rd, wr, a, d);
        q_exp.push_back(exp_dout);
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK); #1;
            if (k == 0) drive(sel, 1'b0, 1'b0, a, d);
            rdy  = sel ? ifb.READY    : ifa.READY;
            bsy  = sel ? ifb.BUSY     : ifa.BUSY;
            err  = sel ? ifb.ERR      : ifa.ERR;
            dout = sel ? ifb.DATA_OUT : ifa.DATA_OUT;
            if (bsy) busy_n++;
            if (rdy) begin
                rdy_n++;
                if (rdy_edge < 0) rdy_edge = k;
                chk({tag, ".dout"}, dout, (q_exp.size() > 0) ? q_exp.pop_front() : 32'hx);
                chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
            end
            if (!bsy) break;
        end
        chk({tag, ".ready_edge"}, rdy_edge, sel ? 0 : 2);
        chk({tag, ".ready_cnt"}, rdy_n, 1);
        chk({tag, ".busy_cycles"}, busy_n, sel ? 1 : 3);
    endtask

    initial begin
        int pulses;
        int first_pos, last_pos, gap_bad;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.ready", {31'd0, ifa.READY}, 32'd0);
        chk("rst.busy",  {31'd0, ifa.BUSY},  32'd0);
        chk("rst.err",   {31'd0, ifa.ERR},   32'd0);
        chk("rst.dout",  ifa.DATA_OUT,       32'd0);
        @(negedge CLK) RST = 1'b0;

        access("wr5",  1'b0, 1'b0, 1'b1, 26'h05, 32'hDEADBEEF, 32'h0, 1'b0);
        access("rd5",  1'b0, 1'b1, 1'b0, 26'h05, 32'h0, 32'hDEADBEEF, 1'b0);
        access("rw5",  1'b0, 1'b1, 1'b1, 26'h05, 32'h1, 32'hDEADBEEF, 1'b0);
        access("rd5b", 1'b0, 1'b1, 1'b0, 26'h05, 32'h0, 32'hDEADBEEF, 1'b0);

`ifdef MEM_ADDR_CHECK_EN
        access("wr105", 1'b0, 1'b0, 1'b1, 26'h105, 32'h12345678, 32'hDEADBEEF, 1'b1);
        access("rd5c",  1'b0, 1'b1, 1'b0, 26'h05, 32'h0, 32'hDEADBEEF, 1'b0);
        access("rd105", 1'b0, 1'b1, 1'b0, 26'h105, 32'h0, 32'hFFFFFFFF, 1'b1);
        last_a = 32'hFFFFFFFF;
`else
        access("wr105", 1'b0, 1'b0, 1'b1, 26'h105, 32'h12345678, 32'hDEADBEEF, 1'b0);
        access("rd5c",  1'b0, 1'b1, 1'b0, 26'h05, 32'h0, 32'h12345678, 1'b0);
        access("rd105", 1'b0, 1'b1, 1'b0, 26'h105, 32'h0, 32'h12345678, 1'b0);
        last_a = 32'h12345678;
`endif

        // Reset during WAIT must abort the write to 0x07.
        access("wr7z", 1'b0, 1'b0, 1'b1, 26'h07, 32'h0, last_a, 1'b0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b1, 26'h07, 32'hCAFEF00D);
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 1'b0, 26'h07, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b1;
        #2;
        chk("abort.ready", {31'd0, ifa.READY}, 32'd0);
        chk("abort.busy",  {31'd0, ifa.BUSY},  32'd0);
        chk("abort.dout",  ifa.DATA_OUT,       32'd0);
        @(negedge CLK) RST = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(posedge CLK); #1;
            if (ifa.READY) pulses++;
        end
        chk("abort.no_ready", pulses, 0);
        access("rd7", 1'b0, 1'b1, 1'b0, 26'h07, 32'h0, 32'h0, 1'b0);

        // Held READ: three pulses every four cycles over twelve edges.
        access("wr0", 1'b0, 1'b0, 1'b1, 26'h00, 32'h0000A5A5, 32'h0, 1'b0);
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b0, 26'h00, 32'h0);
        pulses = 0; first_pos = -1; last_pos = -1; gap_bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK); #1;
            if (ifa.READY) begin
                if (last_pos >= 0 && k - last_pos != 4) gap_bad++;
                if (first_pos < 0) first_pos = k;
                last_pos = k;
                pulses++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 26'h00, 32'h0);
        chk("hold.pulses", pulses, 3);
        chk("hold.first", first_pos, 2);
        chk("hold.gap", gap_bad, 0);
        chk("hold.dout", ifa.DATA_OUT, 32'h0000A5A5);
        repeat (3) @(posedge CLK);
        #1;
        chk("hold.idle", {31'd0, ifa.BUSY}, 32'd0);

        // Zero wait states.
        access("b.wr5", 1'b1, 1'b0, 1'b1, 26'h05, 32'h0BADF00D, 32'h0, 1'b0);
        access("b.rd5", 1'b1, 1'b1, 1'b0, 26'h05, 32'h0, 32'h0BADF00D, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's READ/WRITE memory interface. It accepts single-word requests issued by the control unit during fetch, memory and write-back states. It holds a synchronous word-addressed storage array, inserts a programmable number of wait states, and signals completion with a one-cycle READY pulse. It sits between the processor's memory port and the storage array, as the responder end of the interface the control unit initiates.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 26, request address width in words
- DEPTH_LOG2, 8, log2 of the storage depth in words (256 by default)
- WAIT_CYCLES, 2, wait states inserted before completion (0..15)

Ports:
- CLK  in  1  clock, all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- READ  in  1  read request, level
- WRITE  in  1  write request, level
- ADDR  in  ADDR_WIDTH  word address, sampled with the request
- DATA_IN  in  DATA_WIDTH  write data, sampled with the request
- DATA_OUT  out  DATA_WIDTH  read data, registered
- READY  out  1  completion pulse, one cycle
- BUSY  out  1  high whenever the state is not IDLE
- ERR  out  1  address-range error, valid with READY; tied 0 when the feature is compiled out

## Operation
- State machine has three states: IDLE, WAIT and RESP.
- **IDLE**
  - On a rising edge with READ or WRITE high, capture ADDR, DATA_IN and the operation.
  - If READ and WRITE are both high, READ wins and the write is discarded.
  - Go to WAIT with the counter loaded with WAIT_CYCLES. If WAIT_CYCLES==0, go directly to RESP and perform the access on that edge.
- **WAIT**
  - Counter decrements each edge.
  - On the edge where the counter equals 1, go to RESP and perform the access.
- **Access, on entry to RESP**
  - Write: mem[ADDR[DEPTH_LOG2-1:0]] <= captured data.
  - Read: DATA_OUT <= mem[ADDR[DEPTH_LOG2-1:0]].
- **RESP**
  - READY=1 for exactly this cycle.
  - Next edge returns to IDLE unconditionally.
  - Requests present during WAIT and RESP are ignored.
- Requests are level-sensitive. A request still high in IDLE starts a new access. The requester deasserts before the edge that ends RESP to avoid a repeat.
- Addresses wrap: bits above DEPTH_LOG2 are ignored (unless MEM_ADDR_CHECK_EN is defined).
- DATA_OUT holds its value between reads; writes never change it.
- **Reset**: state IDLE, counter 0, READY 0, BUSY 0, ERR 0, DATA_OUT 0. Array contents are not reset.
- **Reset mid-operation** aborts the access. A write whose RESP entry has not occurred is not performed.

## Timing
- Sampling edge = edge 0. The access happens and READY rises at edge WAIT_CYCLES, including the W=0 case (immediately after the sampling edge).
- READY falls at edge WAIT_CYCLES+1.
- DATA_OUT is valid from the READY rise until the next read completes.
- BUSY rises at edge 0 and falls at edge WAIT_CYCLES+1.
- With a request held continuously, accesses repeat every WAIT_CYCLES+2 cycles.

## Configuration
- Macro: MEM_ADDR_CHECK_EN.
- **Defined**
  - If any captured ADDR bit at or above DEPTH_LOG2 is 1, no array access occurs.
  - On a read, DATA_OUT <= all ones.
  - ERR=1 for the RESP cycle, coincident with READY.
  - Timing is unchanged.
- **Undefined**
  - Out-of-range addresses alias by truncation.
  - ERR is constant 0.

## Test plan
- Default parameters; write 0xDEADBEEF to ADDR 0x05, then read 0x05 -> READY rises 2 edges after each sampling edge; DATA_OUT=0xDEADBEEF; BUSY high 3 cycles per access.
- READ=WRITE=1, ADDR 0x05, DATA_IN 0x00000001 after the previous test -> read performed; DATA_OUT=0xDEADBEEF; mem[0x05] unchanged.
- Write 0x12345678 to ADDR 0x105 -> without the macro, a read of 0x05 returns 0x12345678. With MEM_ADDR_CHECK_EN -> ERR=1 with READY, mem[0x05] unchanged, and a read of 0x105 gives DATA_OUT=0xFFFFFFFF.
- Write 0xCAFEF00D to 0x07 (old value 0x0), RST pulsed during WAIT -> READY never asserts; outputs return to reset values; mem[0x07] reads back 0x0.
- READ held high for 12 cycles at ADDR 0x00 -> exactly 3 READY pulses, spaced 4 cycles apart.
- WAIT_CYCLES=0 instance, read 0x05 -> READY high in the cycle immediately after the sampling edge; BUSY high exactly 1 cycle.
